// File: rtl/bmf_pkg.sv
// Shared types and constants for the Boolean-matrix-factor H decoder.
package bmf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } bmf_state_e;

  localparam int XOR_MODE_OR  = 0;
  localparam int XOR_MODE_XOR = 1;
  localparam int CNT_W        = 32;

endpackage

// File: rtl/bmf_h_reduce.sv
// Combinational reduction: selects basis rows of H by the factor bits of k
// and folds them with OR (Boolean semiring) or XOR (GF(2)).
module bmf_h_reduce
  import bmf_pkg::*;
#(
  parameter int K        = 4,
  parameter int M        = 16,
  parameter int XOR_MODE = XOR_MODE_OR
) (
  input  logic [K-1:0]   i_k,
  input  logic [K*M-1:0] i_h,
  output logic [M-1:0]   o_word
);

  always_comb begin
    o_word = '0;
    for (int j = 0; j < K; j++) begin
      if (i_k[j]) begin
        if (XOR_MODE == XOR_MODE_XOR) o_word = o_word ^ i_h[j*M +: M];
        else                          o_word = o_word | i_h[j*M +: M];
      end
    end
  end

endmodule

// File: rtl/bmf_h_decoder.sv
// Decodes K-bit factor vectors into M-bit words through a loaded basis H,
// with a two-stage valid/ready pipeline and a load/run/drain sequencer.
//
//   state    | meaning
//   ST_IDLE  | no basis loaded, waiting for cfg_start
//   ST_LOAD  | accepting basis rows 0..K-1 in order
//   ST_RUN   | H valid, decoding factor vectors
//   ST_DRAIN | reload requested, emptying pipeline before LOAD
module bmf_h_decoder
  import bmf_pkg::*;
#(
  parameter int K        = 4,
  parameter int M        = 16,
  parameter int XOR_MODE = XOR_MODE_OR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [M-1:0]     cfg_row,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_data,
  output logic             loaded,
  output logic [CNT_W-1:0] dec_count
);

  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(K - 1);

  bmf_state_e       r_state, w_state_nxt;
  logic [RW-1:0]    r_row_cnt, w_row_cnt_nxt, w_wr_idx;
  logic [K*M-1:0]   r_h;
  logic             r_s1_valid, r_s2_valid;
  logic [K-1:0]     r_s1_k;
  logic [M-1:0]     r_s2_data, w_word;
  logic [CNT_W-1:0] r_dec_count;
  logic             w_cfg_hs, w_in_hs, w_out_hs, w_s1_adv, w_s2_adv, w_busy;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_busy    = r_s1_valid || r_s2_valid;
  assign cfg_ready = (r_state == ST_LOAD);
  assign in_ready  = (r_state == ST_RUN) && !cfg_start && w_s1_adv;
  assign loaded    = (r_state == ST_RUN);
  assign w_cfg_hs  = cfg_valid && cfg_ready;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = r_s2_valid && out_ready;
  // A restart coinciding with a row handshake writes that row as row 0.
  assign w_wr_idx  = cfg_start ? '0 : r_row_cnt;

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign dec_count = r_dec_count;

  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) begin
          w_state_nxt   = ST_LOAD;
          w_row_cnt_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (w_cfg_hs) begin
          if (w_wr_idx == LAST_ROW) begin
            w_state_nxt   = ST_RUN;
            w_row_cnt_nxt = '0;
          end else begin
            w_row_cnt_nxt = w_wr_idx + 1'b1;
          end
        end else if (cfg_start) begin
          w_row_cnt_nxt = '0;
        end
      end
      ST_RUN: begin
        if (cfg_start) begin
          w_state_nxt   = w_busy ? ST_DRAIN : ST_LOAD;
          w_row_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        // Leave once the last word is transferring out of stage 2.
        if (!r_s1_valid && w_s2_adv) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row_cnt   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_k      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_dec_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      if (w_s1_adv) begin
        r_s1_valid <= w_in_hs;
        if (w_in_hs) r_s1_k <= in_k;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= w_word;
      end
      if (w_out_hs && (r_dec_count != '1)) r_dec_count <= r_dec_count + 1'b1;
    end
  end

  // H is deliberately left out of reset; it is meaningless until a full load.
  always_ff @(posedge clk) begin
    if (!rst && w_cfg_hs) r_h[w_wr_idx*M +: M] <= cfg_row;
  end

  bmf_h_reduce #(
    .K        (K),
    .M        (M),
    .XOR_MODE (XOR_MODE)
  ) u_reduce (
    .i_k    (r_s1_k),
    .i_h    (r_h),
    .o_word (w_word)
  );

endmodule

// File: tb/tb_bmf_h_decoder.sv
// Scoreboard bench: drives an OR-mode and an XOR-mode decoder with the same
// stimulus and checks every output word against a reference model of H.
module tb_bmf_h_decoder;

  logic        clk = 1'b0;
  logic        rst, cfg_start, cfg_valid, in_valid, out_ready;
  logic [15:0] cfg_row;
  logic [3:0]  in_k;

  logic        cfg_ready_o, in_ready_o, out_valid_o, loaded_o;
  logic [15:0] out_data_o;
  logic [31:0] dec_count_o;
  logic        cfg_ready_x, in_ready_x, out_valid_x, loaded_x;
  logic [15:0] out_data_x;
  logic [31:0] dec_count_x;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] h_m [4];
  logic [15:0] sb_or  [$];
  logic [15:0] sb_xor [$];
  logic        stall_o = 1'b0;
  logic [15:0] stall_d = '0;

  always #5 clk = ~clk;

  bmf_h_decoder #(.K(4), .M(16), .XOR_MODE(0)) dut_or (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready_o), .cfg_row(cfg_row), .in_valid(in_valid),
    .in_ready(in_ready_o), .in_k(in_k), .out_valid(out_valid_o),
    .out_ready(out_ready), .out_data(out_data_o), .loaded(loaded_o),
    .dec_count(dec_count_o)
  );

  bmf_h_decoder #(.K(4), .M(16), .XOR_MODE(1)) dut_xor (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready_x), .cfg_row(cfg_row), .in_valid(in_valid),
    .in_ready(in_ready_x), .in_k(in_k), .out_valid(out_valid_x),
    .out_ready(out_ready), .out_data(out_data_x), .loaded(loaded_x),
    .dec_count(dec_count_x)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [3:0] k, input bit xm);
    logic [15:0] r = '0;
    for (int j = 0; j < 4; j++)
      if (k[j]) r = xm ? (r ^ h_m[j]) : (r | h_m[j]);
    return r;
  endfunction

  // Monitor: push on input handshake, pop/compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_or.delete();
      sb_xor.delete();
      stall_o = 1'b0;
    end else begin
      if (stall_o) begin
        check_val("stall_valid", 32'(out_valid_o), 32'd1);
        check_val("stall_data", 32'(out_data_o), 32'(stall_d));
      end
      stall_o = out_valid_o && !out_ready;
      stall_d = out_data_o;
      if (in_valid && in_ready_o) sb_or.push_back(ref_word(in_k, 1'b0));
      if (in_valid && in_ready_x) sb_xor.push_back(ref_word(in_k, 1'b1));
      if (out_valid_o && out_ready) begin
        check_val("or_expected_avail", 32'(sb_or.size() != 0), 32'd1);
        if (sb_or.size() != 0) check_val("or_data", 32'(out_data_o), 32'(sb_or.pop_front()));
      end
      if (out_valid_x && out_ready) begin
        check_val("xor_expected_avail", 32'(sb_xor.size() != 0), 32'd1);
        if (sb_xor.size() != 0) check_val("xor_data", 32'(out_data_x), 32'(sb_xor.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int n = 0; n < 20 && !cfg_ready_o; n++) step();
    check_val("load_ready", 32'(cfg_ready_o), 32'd1);
  endtask

  task automatic load_rows(input logic [63:0] rows, input int n_rows);
    for (int i = 0; i < n_rows; i++) begin
      cfg_valid = 1'b1;
      cfg_row   = rows[16*i +: 16];
      h_m[i]    = rows[16*i +: 16];
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_k(input logic [3:0] k);
    bit hs = 1'b0;
    in_valid = 1'b1;
    in_k     = k;
    for (int n = 0; n < 50 && !hs; n++) begin
      #1;
      hs = in_ready_o;
      @(posedge clk);
      #2;
    end
    check_val("send_handshake", 32'(hs), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [3:0] stream_k [8] = '{4'b1011, 4'b0011, 4'b0000, 4'b1111,
                               4'b0100, 4'b1000, 4'b0110, 4'b0001};

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_row = '0;
    in_valid = 1'b0; in_k = '0; out_ready = 1'b1;
    idle(3);
    check_val("rst_out_valid", 32'(out_valid_o), 32'd0);
    check_val("rst_out_data", 32'(out_data_o), 32'd0);
    check_val("rst_cfg_ready", 32'(cfg_ready_o), 32'd0);
    check_val("rst_in_ready", 32'(in_ready_o), 32'd0);
    check_val("rst_loaded", 32'(loaded_o), 32'd0);
    check_val("rst_dec_count", dec_count_o, 32'd0);
    rst = 1'b0;
    step();

    // Load H = {0x0001, 0x0010, 0x0100, 0x8000}
    start_load();
    load_rows({16'h8000, 16'h0100, 16'h0010, 16'h0001}, 4);
    check_val("run_loaded", 32'(loaded_o), 32'd1);
    check_val("run_cfg_ready", 32'(cfg_ready_o), 32'd0);

    // Back-to-back stream under out_ready pattern 1,0,0,1
    fork
      begin
        for (int i = 0; i < 8; i++) send_k(stream_k[i]);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = (c % 4 == 0) || (c % 4 == 3);
          step();
        end
        out_ready = 1'b1;
      end
    join
    idle(4);
    check_val("stream_dec_count_or", dec_count_o, 32'd8);
    check_val("stream_dec_count_xor", dec_count_x, 32'd8);

    // Two-cycle latency: 1011 -> 0x8011 in both semirings
    in_valid = 1'b1; in_k = 4'b1011;
    #1;
    check_val("lat_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    check_val("lat_cycle1_valid", 32'(out_valid_o), 32'd0);
    step();
    check_val("lat_cycle2_valid", 32'(out_valid_o), 32'd1);
    check_val("lat_or_data", 32'(out_data_o), 32'h8011);
    check_val("lat_xor_data", 32'(out_data_x), 32'h8011);
    idle(2);

    // Reload request with two words in flight
    out_ready = 1'b0;
    send_k(4'b0011);
    send_k(4'b1100);
    out_ready = 1'b1; in_valid = 1'b1; in_k = 4'b1111; cfg_start = 1'b1;
    #1;
    check_val("reload_in_ready_drop", 32'(in_ready_o), 32'd0);
    @(posedge clk); #2;
    cfg_start = 1'b0; in_valid = 1'b0;
    check_val("drain_loaded", 32'(loaded_o), 32'd0);
    check_val("drain_cfg_ready", 32'(cfg_ready_o), 32'd0);
    for (int n = 0; n < 20 && !cfg_ready_o; n++) step();
    check_val("drain_to_load", 32'(cfg_ready_o), 32'd1);
    check_val("drain_delivered", 32'(sb_or.size()), 32'd0);
    load_rows({16'h8000, 16'h0100, 16'h0001, 16'h0001}, 4);
    send_k(4'b0011);
    step();
    check_val("newh_or_data", 32'(out_data_o), 32'h0001);
    check_val("newh_xor_data", 32'(out_data_x), 32'h0000);
    idle(3);

    // Reset after a partial load
    start_load();
    load_rows({16'h0000, 16'h0000, 16'h2000, 16'h0004}, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("prst_loaded", 32'(loaded_o), 32'd0);
    check_val("prst_cfg_ready", 32'(cfg_ready_o), 32'd0);
    check_val("prst_dec_count", dec_count_o, 32'd0);
    idle(2);
    check_val("prst_stays_idle", 32'(cfg_ready_o), 32'd0);
    start_load();
    load_rows({16'h0F00, 16'h00F0, 16'h2000, 16'h0004}, 4);
    check_val("prst_reload_run", 32'(loaded_o), 32'd1);
    send_k(4'b1110);
    idle(3);

    // dec_count saturation
    force dut_or.r_dec_count = 32'hFFFF_FFFE;
    force dut_xor.r_dec_count = 32'hFFFF_FFFE;
    #1;
    release dut_or.r_dec_count;
    release dut_xor.r_dec_count;
    send_k(4'b0101);
    idle(3);
    check_val("sat_reach_max", dec_count_o, 32'hFFFF_FFFF);
    send_k(4'b1010);
    idle(3);
    check_val("sat_hold_or", dec_count_o, 32'hFFFF_FFFF);
    check_val("sat_hold_xor", dec_count_x, 32'hFFFF_FFFF);

    check_val("sb_or_empty", 32'(sb_or.size()), 32'd0);
    check_val("sb_xor_empty", 32'(sb_xor.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
